// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_FIFO_DEPTH = 2;
    localparam int unsigned FETCH_CNT_W      = $clog2(FETCH_FIFO_DEPTH + 1);
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    // One buffered fetch result: the instruction word and the PC it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, decode handshake and
// execute redirect.
//   master (fetch side): drives pc_o, out_valid, out_pc, out_inst
//   slave  (memory/decode/execute side): drives inst_i, out_ready,
//                                        redirect_valid, redirect_pc
interface instruction_fetch_if;

    logic [31:0] pc_o;
    logic [31:0] inst_i;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output pc_o, out_valid, out_pc, out_inst,
        input  inst_i, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  pc_o, out_valid, out_pc, out_inst,
        output inst_i, out_ready, redirect_valid, redirect_pc
    );

endinterface : instruction_fetch_if

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of fetch entries with flush.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : drop all entries (priority over push/pop)
//   push, data_i : enqueue data_i when there is room or a pop frees a slot
//   pop          : dequeue head when not empty
//   head         : registered head entry (holds last value when empty)
//   count        : number of valid entries, 0..2
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  fetch_entry_t           data_i,
    output fetch_entry_t           head,
    output logic [FETCH_CNT_W-1:0] count
);

    localparam logic [FETCH_CNT_W-1:0] DEPTH = FETCH_CNT_W'(FETCH_FIFO_DEPTH);

    fetch_entry_t           head_q;
    fetch_entry_t           tail_q;
    logic [FETCH_CNT_W-1:0] count_q;
    logic                   do_pop_c;
    logic                   do_push_c;

    assign do_pop_c  = pop && (count_q != '0);
    assign do_push_c = push && ((count_q < DEPTH) || do_pop_c);

    // Shift-register FIFO: head_q is always the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            head_q  <= fetch_entry_t'{pc: RESET_PC, inst: NOP_INST};
            tail_q  <= fetch_entry_t'{pc: RESET_PC, inst: NOP_INST};
        end else if (flush) begin
            count_q <= '0;
        end else begin
            if (do_pop_c && (count_q == DEPTH)) begin
                head_q <= tail_q;
            end
            if (do_push_c) begin
                // New entry lands in head when the FIFO becomes/stays one deep.
                if ((count_q == '0) || ((count_q == FETCH_CNT_W'(1)) && do_pop_c)) begin
                    head_q <= data_i;
                end else begin
                    tail_q <= data_i;
                end
            end
            count_q <= count_q + FETCH_CNT_W'(do_push_c) - FETCH_CNT_W'(do_pop_c);
        end
    end

    assign head  = head_q;
    assign count = count_q;

endmodule : fetch_skid_fifo

// File: rtl/instruction_fetch.sv
// Fetch-stage initiator: drives the fetch PC to instruction memory, buffers
// returned words with their PCs in a 2-entry FIFO, and hands them to decode
// over valid/ready. Execute redirects flush the buffer and retarget fetch.
//   clk, rst : clock, synchronous active-high reset
//   bus      : instruction_fetch_if.master (pc_o/inst_i, out_* handshake,
//              redirect_valid/redirect_pc)
//   perf_fetched, perf_stalled : saturating counters, only when the
//              FETCH_PERF_CNT_EN macro is defined
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_fetch_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stalled
`endif
);

    // Word-aligned address mask; also makes the PC wrap at IMEM_BYTES.
    localparam logic [31:0]            PC_MASK = 32'(IMEM_BYTES - 1) & 32'hFFFF_FFFC;
    localparam logic [FETCH_CNT_W-1:0] DEPTH   = FETCH_CNT_W'(FETCH_FIFO_DEPTH);

    logic [31:0]            fetch_pc_q;
    logic [FETCH_CNT_W-1:0] count;
    fetch_entry_t           head;
    logic                   pop_c;
    logic                   push_c;

    assign pop_c  = bus.out_valid && bus.out_ready;
    assign push_c = !bus.redirect_valid && ((count < DEPTH) || pop_c);

    // Fetch PC is stored already masked so pc_o comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC & PC_MASK;
        end else if (bus.redirect_valid) begin
            fetch_pc_q <= {bus.redirect_pc[31:2], 2'b00} & PC_MASK;
        end else if (push_c) begin
            fetch_pc_q <= (fetch_pc_q + 32'd4) & PC_MASK;
        end
    end

    fetch_skid_fifo #(
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (bus.redirect_valid),
        .push   (push_c),
        .pop    (pop_c),
        .data_i (fetch_entry_t'{pc: fetch_pc_q, inst: bus.inst_i}),
        .head   (head),
        .count  (count)
    );

    assign bus.pc_o      = fetch_pc_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = head.pc;
    assign bus.out_inst  = head.inst;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stalled_q;

    // Saturating event counters: pushes, and cycles blocked on a full buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stalled_q <= '0;
        end else begin
            if (push_c && (perf_fetched_q != 32'hFFFF_FFFF)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if ((count == DEPTH) && !pop_c && (perf_stalled_q != 32'hFFFF_FFFF)) begin
                perf_stalled_q <= perf_stalled_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stalled = perf_stalled_q;
`endif

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a combinational memory model
// and a queue of expected fetch PCs.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] mem [64];
    logic [31:0] exp_q [$];

    instruction_fetch_if bus();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalled;
`endif

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (256)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stalled (perf_stalled)
`endif
    );

    always #5 clk = ~clk;

    assign bus.inst_i = mem[bus.pc_o[7:2]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare the visible head against the next expected PC and its memory word.
    task automatic test_stream();
        logic [31:0] e;
        bus.out_ready = 1'b1;
        rst = 1'b0;
        n_vec++;
        if (bus.pc_o !== 32'h0) begin
            n_err++; $display("FAIL stream_first_pc_o: got %h expected %h", bus.pc_o, 32'h0);
        end
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 4; i++) begin
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (bus.out_valid !== 1'b1) begin
                n_err++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, bus.out_valid);
            end
            n_vec++;
            if (bus.out_pc !== e) begin
                n_err++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, bus.out_pc, e);
            end
            n_vec++;
            if (bus.out_inst !== mem[e[7:2]]) begin
                n_err++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, bus.out_inst, mem[e[7:2]]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        step();
        step();
        n_vec++;
        if (bus.pc_o !== 32'h0) begin
            n_err++; $display("FAIL reset_pc_o: got %h expected %h", bus.pc_o, 32'h0);
        end
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
        end
        n_vec++;
        if (bus.out_pc !== 32'h0) begin
            n_err++; $display("FAIL reset_out_pc: got %h expected %h", bus.out_pc, 32'h0);
        end
        n_vec++;
        if (bus.out_inst !== 32'h13) begin
            n_err++; $display("FAIL reset_out_inst: got %h expected %h", bus.out_inst, 32'h13);
        end
`ifdef FETCH_PERF_CNT_EN
        n_vec++;
        if (perf_fetched !== 32'h0 || perf_stalled !== 32'h0) begin
            n_err++; $display("FAIL reset_perf: got %h/%h expected 0/0", perf_fetched, perf_stalled);
        end
`endif
    endtask

    // Back-pressure: hold out_ready low for 5 cycles with 0x4 at the head.
    task automatic test_stall();
        logic [31:0] e;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4) begin
                n_err++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, bus.out_valid, bus.out_pc, 32'h4);
            end
            n_vec++;
            if (bus.pc_o !== 32'hC) begin
                n_err++; $display("FAIL stall_pc_o[%0d]: got %h expected %h", i, bus.pc_o, 32'hC);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        n_vec++;
        if (perf_fetched !== 32'd3) begin
            n_err++; $display("FAIL stall_perf_fetched: got %0d expected 3", perf_fetched);
        end
        n_vec++;
        if (perf_stalled !== 32'd4) begin
            n_err++; $display("FAIL stall_perf_stalled: got %0d expected 4", perf_stalled);
        end
`endif
        bus.out_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== e || bus.out_inst !== mem[e[7:2]]) begin
                n_err++; $display("FAIL stall_resume[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                                  i, bus.out_valid, bus.out_pc, bus.out_inst, e, mem[e[7:2]]);
            end
            step();
        end
    endtask

    // Redirect to 0x40 with a full buffer and decode stalled.
    task automatic test_redirect();
        logic [31:0] e;
        bus.out_ready = 1'b0;
        step();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL redirect_bubble: got %b expected 0", bus.out_valid);
        end
        n_vec++;
        if (bus.pc_o !== 32'h40) begin
            n_err++; $display("FAIL redirect_pc_o: got %h expected %h", bus.pc_o, 32'h40);
        end
        exp_q.delete();
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== e || bus.out_inst !== mem[e[7:2]]) begin
                n_err++; $display("FAIL redirect_target[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                                  i, bus.out_valid, bus.out_pc, bus.out_inst, e, mem[e[7:2]]);
            end
            step();
        end
    endtask

    // Misaligned redirect target: low address bits are dropped.
    task automatic test_misaligned();
        logic [31:0] e;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h47;
        step();
        bus.redirect_valid = 1'b0;
        n_vec++;
        if (bus.pc_o !== 32'h44 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL misaligned_pc_o: got pc=%h v=%b expected pc=%h v=0", bus.pc_o, bus.out_valid, 32'h44);
        end
        exp_q.delete();
        exp_q.push_back(32'h44);
        exp_q.push_back(32'h48);
        exp_q.push_back(32'h4C);
        step();
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== e || bus.out_inst !== mem[e[7:2]]) begin
                n_err++; $display("FAIL misaligned_seq[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                                  i, bus.out_valid, bus.out_pc, bus.out_inst, e, mem[e[7:2]]);
            end
            step();
        end
    endtask

    // Fetch runs off the top of the 256-byte memory and wraps to 0.
    task automatic test_wrap();
        logic [31:0] e;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hF8;
        step();
        bus.redirect_valid = 1'b0;
        n_vec++;
        if (bus.pc_o !== 32'hF8) begin
            n_err++; $display("FAIL wrap_start_pc_o: got %h expected %h", bus.pc_o, 32'hF8);
        end
        exp_q.delete();
        exp_q.push_back(32'hF8);
        exp_q.push_back(32'hFC);
        exp_q.push_back(32'h00);
        exp_q.push_back(32'h04);
        step();
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== e || bus.out_inst !== mem[e[7:2]]) begin
                n_err++; $display("FAIL wrap_seq[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                                  i, bus.out_valid, bus.out_pc, bus.out_inst, e, mem[e[7:2]]);
            end
            if (i == 1) begin
                n_vec++;
                if (bus.pc_o !== 32'h0) begin
                    n_err++; $display("FAIL wrap_pc_o: got %h expected %h", bus.pc_o, 32'h0);
                end
            end
            step();
        end
    endtask

    // Reset together with a redirect while the buffer is full.
    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h80;
        step();
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.pc_o !== 32'h0) begin
            n_err++; $display("FAIL rstmid_state: got v=%b pc_o=%h expected v=0 pc_o=%h", bus.out_valid, bus.pc_o, 32'h0);
        end
        n_vec++;
        if (bus.out_inst !== 32'h13 || bus.out_pc !== 32'h0) begin
            n_err++; $display("FAIL rstmid_head: got pc=%h inst=%h expected pc=%h inst=%h", bus.out_pc, bus.out_inst, 32'h0, 32'h13);
        end
`ifdef FETCH_PERF_CNT_EN
        n_vec++;
        if (perf_fetched !== 32'h0 || perf_stalled !== 32'h0) begin
            n_err++; $display("FAIL rstmid_perf: got %h/%h expected 0/0", perf_fetched, perf_stalled);
        end
`endif
        step();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_inst !== mem[0]) begin
            n_err++; $display("FAIL rstmid_restart: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                              bus.out_valid, bus.out_pc, bus.out_inst, 32'h0, mem[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch-stage initiator for the instruction-memory port: holds the fetch PC and presents it to the word-wide, combinational `InstructionMemory` read port. It captures each returned instruction with its PC into a two-entry buffer and hands the pair to decode over a valid/ready handshake. It also absorbs branch/jump redirects from execute, flushing all buffered wrong-path instructions.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch PC loaded on reset
- `IMEM_BYTES`, 256, instruction memory size in bytes (power of two); bounds the fetch address
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `pc_o`  out  32  byte address to instruction memory
- `inst_i`  in  32  instruction word returned combinationally for `pc_o` in the same cycle
- `out_valid`  out  1  buffer head holds an instruction for decode
- `out_pc`  out  32  PC of head instruction
- `out_inst`  out  32  head instruction word
- `out_ready`  in  1  decode accepts head this cycle
- `redirect_valid`  in  1  execute requests PC change (taken branch/jump)
- `redirect_pc`  in  32  redirect target
- `perf_fetched`, `perf_stalled`  out  32 each  present only with `FETCH_PERF_CNT_EN` (see Configuration)

## Operation
- State: `fetch_pc` register; 2-entry FIFO of {pc, inst}; count 0..2.
- `pc_o = fetch_pc & (IMEM_BYTES-1)`, word aligned. Bits [1:0] are always 0.
- Push condition: `!redirect_valid && (count<2 || pop)`. On push, the FIFO captures {`pc_o`, `inst_i`} and `fetch_pc <= fetch_pc + 4`. The increment wraps modulo `IMEM_BYTES` through the mask.
- Pop condition: `out_valid && out_ready`. The head is dropped and the next entry is exposed.
- Simultaneous push and pop at count 2: both occur; count stays 2.
- Redirect priority over everything:
  - FIFO is cleared (count <= 0).
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`; misaligned low bits are dropped silently.
  - No push that cycle.
  - A handshake completing in the redirect cycle counts as accepted. Decode/execute squash it themselves.
- `out_valid = (count != 0)`. `out_pc`/`out_inst` come from FIFO head registers and hold stable while `out_valid && !out_ready`.
- When count is 0, `out_pc`/`out_inst` hold their last values and are don't-care.
- Reset in any cycle, including mid-stream or concurrent with a redirect, wins over all other inputs:
  - `fetch_pc <= RESET_PC`, count <= 0.
  - head registers <= {RESET_PC, 32'h0000_0013 (NOP)}.
  - perf counters <= 0.

## Timing
- Reset values: `pc_o` = `RESET_PC` masked; `out_valid`=0; `out_pc`=`RESET_PC`; `out_inst`=32'h13; perf counters 0.
- First cycle after `rst` falls: `pc_o`=`RESET_PC`. On the next edge, `out_valid`=1 with that PC and word. Fetch-to-decode latency is 1 cycle.
- With `out_ready` held high: throughput is 1 instruction/cycle and `out_pc` advances by 4 each cycle.
- With `out_ready` low from cycle N: the FIFO fills by N+2. `pc_o` then freezes at head PC+8 until a pop frees a slot.
- Redirect asserted in cycle R:
  - `out_valid`=0 in R+1, and `pc_o`=target in R+1.
  - Target instruction is valid in R+2.
  - Redirect penalty: 2 bubbles.
- No combinational path from `out_ready` or `redirect_valid` to `out_valid`/`out_pc`/`out_inst`. A combinational path from `out_ready`/`redirect_valid` to the push decision is allowed.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds ports `perf_fetched` and `perf_stalled`.
  - `perf_fetched` increments on every push.
  - `perf_stalled` increments each cycle with count==2 and no pop (fetch blocked).
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Package `fetch_pkg`:
  - `fetch_entry_t` packed struct {pc[31:0], inst[31:0]}
  - `NOP_INST` = 32'h0000_0013
  - `FETCH_FIFO_DEPTH` = 2
- Sub-module `fetch_skid_fifo`: 2-entry FIFO of `fetch_entry_t` with push, pop, flush and count. Flush has priority; push and pop are concurrent-safe.
- `instruction_fetch` owns `fetch_pc`, push/redirect control and perf counters.

## Test plan
- Reset release, `RESET_PC`=0, `out_ready`=1, memory preloaded with words W0..W3 at 0x0..0xC:
  - first valid cycle after `rst` falls shows `out_pc`=0x0, `out_inst`=W0;
  - then 0x4/W1, 0x8/W2, 0xC/W3 on consecutive cycles.
- `out_ready`=0 for 5 cycles starting at 0x4 in flight:
  - `out_pc`=0x4 holds stable;
  - `pc_o` freezes at 0xC;
  - resuming yields 0x4, 0x8, 0xC with no gap or duplicate.
- `redirect_valid` with `redirect_pc`=0x40 while the FIFO is full:
  - next cycle `out_valid`=0 and `pc_o`=0x40;
  - following cycle `out_pc`=0x40.
- `redirect_pc`=0x47 → fetch resumes at 0x44.
- Fetch runs past 0xFC with `IMEM_BYTES`=256 → `pc_o` wraps to 0x00 and `out_pc`=0x00 follows 0xFC.
- `rst` pulsed while the FIFO holds 2 entries and `redirect_valid`=1:
  - next cycle `out_valid`=0, `pc_o`=`RESET_PC`, `out_inst`=0x13;
  - with the macro defined, `perf_fetched`=0.
